spi_slave_if: RTL and testbench

//   SPI slave front end feeding the single-port RAM. Deserialises MOSI frames into

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_bus_if.sv | 39 +++
 rtl/spi_piso.sv | 28 ++
 rtl/spi_slave_if.sv | 153 +++++++++++++++
 tb/tb_spi_slave_if.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // Pick the frame state from the command bit; a read is a data read only
  // when an address read has already completed.
  function automatic spi_state_t cmd_route(input logic cmd_bit, input logic rd_addr_seen);
    logic [1:0] op;
    op = {cmd_bit, cmd_bit & rd_addr_seen};
    case (op)
      OP_WR_ADDR, OP_WR_DATA: cmd_route = WRITE;
      OP_RD_ADDR:             cmd_route = READ_ADD;
      OP_RD_DATA:             cmd_route = READ_DATA;
      default:                cmd_route = WRITE;
    endcase
  endfunction

endpackage

// File: rtl/spi_bus_if.sv
// SPI pins plus RAM-side rx/tx handshake. Optional frame_err under SPI_FRAME_ERR_EN.
interface spi_bus_if #(
  parameter int unsigned ADDR_SIZE = 8
);
  localparam int unsigned RX_W = ADDR_SIZE + 2;

  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [RX_W-1:0]      rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;

`ifdef SPI_FRAME_ERR_EN
  logic                 frame_err;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, frame_err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, frame_err
  );
`else
  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
`endif

endinterface

// File: rtl/spi_piso.sv
// Parallel-in serial-out shifter, MSB first, zero-filled from the LSB end.
module spi_piso #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  // Load takes priority over shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI frames for the RAM and serialises read data on MISO.
// Optional feature: SPI_FRAME_ERR_EN adds a frame_err pulse on aborted frames/shifts.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  spi_bus_if.slave  bus
);

  localparam int unsigned RX_W  = ADDR_SIZE + 2;
  localparam int unsigned CNT_W = $clog2(RX_W) + 1;
  localparam int unsigned TXC_W = $clog2(ADDR_SIZE + 1);

  spi_state_t       state;
  spi_state_t       state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [RX_W-2:0]  rx_shift;
  logic [RX_W-1:0]  rx_data_q;
  logic             rx_valid_q;
  logic             miso_q;
  logic             rd_addr_seen;
  logic             tx_busy;
  logic             tx_done;
  logic [TXC_W-1:0] tx_left;
  logic             piso_msb;

  logic             shift_en;
  logic             frame_done;
  logic             frame_end;
  logic             tx_load;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-clock control strobes
  always_comb begin
    state_nxt  = state;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    frame_end  = 1'b0;
    tx_load    = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.SS_n) state_nxt = CHK_CMD;
      end
      CHK_CMD: begin
        if (bus.SS_n) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end else begin
          shift_en  = 1'b1;
          state_nxt = cmd_route(bus.MOSI, rd_addr_seen);
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (bus.SS_n) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end else if (bit_cnt < CNT_W'(RX_W)) begin
          shift_en   = 1'b1;
          frame_done = (bit_cnt == CNT_W'(RX_W - 1));
        end else if ((state == READ_DATA) && bus.tx_valid && !tx_busy && !tx_done) begin
          tx_load = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Receive shifter, frame output and read-address tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid_q <= frame_done;
      if (frame_end)     bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + CNT_W'(1);
      if (shift_en)   rx_shift  <= {rx_shift[RX_W-3:0], bus.MOSI};
      if (frame_done) rx_data_q <= {rx_shift, bus.MOSI};
      if (frame_done && (state == READ_ADD))       rd_addr_seen <= 1'b1;
      else if (frame_done && (state == READ_DATA)) rd_addr_seen <= 1'b0;
    end
  end

  // Transmit sequencing: one load, then ADDR_SIZE bits, then idle low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_q  <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_left <= '0;
    end else if (frame_end) begin
      miso_q  <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_left <= '0;
    end else if (tx_load) begin
      tx_busy <= 1'b1;
      tx_left <= TXC_W'(ADDR_SIZE);
    end else if (tx_busy) begin
      miso_q  <= piso_msb;
      tx_left <= tx_left - TXC_W'(1);
      if (tx_left == TXC_W'(1)) begin
        tx_busy <= 1'b0;
        tx_done <= 1'b1;
      end
    end else begin
      miso_q <= 1'b0;
    end
  end

  spi_piso #(
    .WIDTH (ADDR_SIZE)
  ) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tx_load),
    .shift (tx_busy && !frame_end),
    .din   (bus.tx_data),
    .msb   (piso_msb)
  );

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

`ifdef SPI_FRAME_ERR_EN
  logic frame_err_q;

  // Flag a frame closed part-way through receive or through a MISO shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_end &&
                     (((bit_cnt != '0) && (bit_cnt < CNT_W'(RX_W))) || tx_busy);
    end
  end

  assign bus.frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: random frames checked against a frame-level model.
module tb_spi_slave_if;
  import spi_pkg::*;

  localparam int unsigned ADDR_SIZE = 8;
  localparam int unsigned RX_W      = ADDR_SIZE + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Frame-level model: last completed frame and whether an address read is pending
  logic [RX_W-1:0] m_rx_data = '0;
  bit              m_rd_seen = 1'b0;

  spi_bus_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

  spi_slave_if #(.ADDR_SIZE(ADDR_SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Where a frame with this first bit lands, from the opcode rules
  function automatic spi_state_t exp_route(input logic [RX_W-1:0] w);
    if (w[RX_W-1] == 1'b0) return WRITE;
    return m_rd_seen ? READ_DATA : READ_ADD;
  endfunction

  function automatic void model_complete(input logic [RX_W-1:0] w);
    spi_state_t s;
    s = exp_route(w);
    if (s == READ_ADD)       m_rd_seen = 1'b1;
    else if (s == READ_DATA) m_rd_seen = 1'b0;
    m_rx_data = w;
  endfunction

  // Drive a full frame (SS_n stays low) plus extra junk bits; report rx_valid activity
  task automatic send_frame(input logic [RX_W-1:0] word, input int extra,
                            output int vcount, output int vlat, output logic [RX_W-1:0] got);
    int idx;
    vcount = 0; vlat = -1; got = '0; idx = 0;
    bus.SS_n = 1'b0;
    bus.MOSI = 1'($urandom);
    tick();
    for (int i = RX_W - 1; i >= 0; i--) begin
      bus.MOSI = word[i];
      tick();
      idx++;
      if (bus.rx_valid === 1'b1) begin
        vcount++;
        if (vlat < 0) begin vlat = idx - int'(RX_W) + 1; got = bus.rx_data; end
      end
    end
    for (int i = 0; i < extra; i++) begin
      bus.MOSI = 1'($urandom);
      tick();
      idx++;
      if (bus.rx_valid === 1'b1) begin
        vcount++;
        if (vlat < 0) begin vlat = idx - int'(RX_W) + 1; got = bus.rx_data; end
      end
    end
  endtask

  task automatic end_frame();
    bus.SS_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.MISO !== 1'b0) $display("FAIL reset_miso: got %b exp 0", bus.MISO); else n_pass++;
    n_checks++; if (bus.rx_data !== '0) $display("FAIL reset_rx_data: got %h exp 000", bus.rx_data); else n_pass++;
    n_checks++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b exp 0", bus.rx_valid); else n_pass++;
    n_checks++; if (dut.state !== IDLE) $display("FAIL reset_state: got %0d exp %0d", dut.state, IDLE); else n_pass++;
    n_checks++; if (dut.rd_addr_seen !== 1'b0) $display("FAIL reset_rd_seen: got %b exp 0", dut.rd_addr_seen); else n_pass++;
  endtask

  task automatic test_write();
    logic [RX_W-1:0] w, got;
    int vc, vl, ex;
    spi_state_t s;
    for (int k = 0; k < 8; k++) begin
      if (k == 0)      w = 10'h0A5;
      else if (k == 1) w = 10'h1F0;
      else             w = {1'b0, 9'($urandom)};
      ex = $urandom_range(1, 4);
      s  = exp_route(w);
      send_frame(w, ex, vc, vl, got);
      n_checks++; if (vc !== 1) $display("FAIL wr_valid_count[%0d]: got %0d exp 1", k, vc); else n_pass++;
      n_checks++; if (vl !== 1) $display("FAIL wr_valid_latency[%0d]: got %0d exp 1", k, vl); else n_pass++;
      n_checks++; if (got !== w) $display("FAIL wr_rx_data[%0d]: got %h exp %h", k, got, w); else n_pass++;
      n_checks++; if (dut.state !== s) $display("FAIL wr_state_hold[%0d]: got %0d exp %0d", k, dut.state, s); else n_pass++;
      end_frame();
      model_complete(w);
      n_checks++; if (dut.state !== IDLE) $display("FAIL wr_state_idle[%0d]: got %0d exp %0d", k, dut.state, IDLE); else n_pass++;
      n_checks++; if (bus.rx_data !== m_rx_data) $display("FAIL wr_rx_hold[%0d]: got %h exp %h", k, bus.rx_data, m_rx_data); else n_pass++;
    end
  endtask

  task automatic test_read();
    logic [RX_W-1:0] w, got;
    logic [ADDR_SIZE-1:0] d;
    int vc, vl, d_wait, extra_v, miso_err;
    spi_state_t s;
    for (int r = 0; r < 4; r++) begin
      w = (r == 0) ? 10'h203 : {2'b10, 8'($urandom)};
      s = exp_route(w);
      send_frame(w, 1, vc, vl, got);
      n_checks++; if (vc !== 1 || got !== w) $display("FAIL rd_addr_frame[%0d]: got %0d/%h exp 1/%h", r, vc, got, w); else n_pass++;
      n_checks++; if (dut.state !== s) $display("FAIL rd_addr_state[%0d]: got %0d exp %0d", r, dut.state, s); else n_pass++;
      end_frame();
      model_complete(w);
      n_checks++; if (dut.rd_addr_seen !== m_rd_seen) $display("FAIL rd_addr_seen_set[%0d]: got %b exp %b", r, dut.rd_addr_seen, m_rd_seen); else n_pass++;

      w      = {2'b11, 8'($urandom)};
      d      = (r == 0) ? 8'hC3 : 8'($urandom);
      d_wait = (r == 0) ? 3 : int'($urandom_range(0, 4));
      s      = exp_route(w);
      send_frame(w, 0, vc, vl, got);
      n_checks++; if (vc !== 1 || vl !== 1 || got !== w) $display("FAIL rd_data_frame[%0d]: got %0d/%0d/%h exp 1/1/%h", r, vc, vl, got, w); else n_pass++;
      n_checks++; if (dut.state !== s) $display("FAIL rd_data_state[%0d]: got %0d exp %0d", r, dut.state, s); else n_pass++;
      model_complete(w);
      extra_v = 0; miso_err = 0;
      for (int i = 0; i < d_wait; i++) begin
        bus.tx_valid = 1'b0; bus.tx_data = 8'($urandom);
        tick();
        if (bus.rx_valid !== 1'b0) extra_v++;
        if (bus.MISO !== 1'b0) miso_err++;
      end
      bus.tx_valid = 1'b1; bus.tx_data = d;
      tick();
      if (bus.rx_valid !== 1'b0) extra_v++;
      if (bus.MISO !== 1'b0) miso_err++;
      bus.tx_data = ~d;
      for (int i = 0; i < int'(ADDR_SIZE); i++) begin
        tick();
        n_checks++;
        if (bus.MISO !== d[ADDR_SIZE-1-i]) $display("FAIL rd_miso_bit[%0d][%0d]: got %b exp %b", r, i, bus.MISO, d[ADDR_SIZE-1-i]);
        else n_pass++;
      end
      for (int i = 0; i < 3; i++) begin
        tick();
        if (bus.rx_valid !== 1'b0) extra_v++;
        if (bus.MISO !== 1'b0) miso_err++;
      end
      n_checks++; if (extra_v !== 0) $display("FAIL rd_extra_valid[%0d]: got %0d exp 0", r, extra_v); else n_pass++;
      n_checks++; if (miso_err !== 0) $display("FAIL rd_miso_idle[%0d]: got %0d exp 0", r, miso_err); else n_pass++;
      bus.tx_valid = 1'b0;
      end_frame();
      n_checks++; if (dut.rd_addr_seen !== m_rd_seen) $display("FAIL rd_seen_clear[%0d]: got %b exp %b", r, dut.rd_addr_seen, m_rd_seen); else n_pass++;
    end
  endtask

  task automatic test_read_routing();
    logic [RX_W-1:0] w, got;
    int vc, vl, miso_err;
    spi_state_t s;
    w = 10'h300;
    s = exp_route(w);
    send_frame(w, 2, vc, vl, got);
    n_checks++; if (vc !== 1 || got !== 10'h300) $display("FAIL route_frame: got %0d/%h exp 1/300", vc, got); else n_pass++;
    n_checks++; if (dut.state !== s) $display("FAIL route_state: got %0d exp %0d", dut.state, s); else n_pass++;
    miso_err = 0;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.tx_data = 8'($urandom) | 8'h80;
      tick();
      if (bus.MISO !== 1'b0) miso_err++;
    end
    bus.tx_valid = 1'b0;
    n_checks++; if (miso_err !== 0) $display("FAIL route_no_miso: got %0d exp 0", miso_err); else n_pass++;
    end_frame();
    model_complete(w);
    n_checks++; if (dut.rd_addr_seen !== m_rd_seen) $display("FAIL route_seen: got %b exp %b", dut.rd_addr_seen, m_rd_seen); else n_pass++;
    w = {2'b01, 8'($urandom)};
    send_frame(w, 1, vc, vl, got);
    end_frame();
    model_complete(w);
    n_checks++; if (dut.rd_addr_seen !== m_rd_seen) $display("FAIL route_seen_after_wr: got %b exp %b", dut.rd_addr_seen, m_rd_seen); else n_pass++;
  endtask

  task automatic test_random_mix();
    logic [RX_W-1:0] w, got;
    int vc, vl;
    spi_state_t s;
    for (int k = 0; k < 12; k++) begin
      w = RX_W'($urandom);
      s = exp_route(w);
      send_frame(w, $urandom_range(1, 3), vc, vl, got);
      n_checks++; if (vc !== 1 || vl !== 1 || got !== w) $display("FAIL mix_frame[%0d]: got %0d/%0d/%h exp 1/1/%h", k, vc, vl, got, w); else n_pass++;
      n_checks++; if (dut.state !== s) $display("FAIL mix_state[%0d]: got %0d exp %0d", k, dut.state, s); else n_pass++;
      end_frame();
      model_complete(w);
      n_checks++; if (dut.rd_addr_seen !== m_rd_seen) $display("FAIL mix_seen[%0d]: got %b exp %b", k, dut.rd_addr_seen, m_rd_seen); else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [RX_W-1:0] w, got;
    logic [ADDR_SIZE-1:0] d;
    int vc, vl, k;
    for (int t = 0; t < 5; t++) begin
      k = (t == 0) ? 5 : (t == 1) ? 0 : int'($urandom_range(1, RX_W - 1));
      vc = 0;
      bus.SS_n = 1'b0;
      tick();
      for (int i = 0; i < k; i++) begin
        bus.MOSI = 1'($urandom);
        tick();
        if (bus.rx_valid === 1'b1) vc++;
      end
      end_frame();
      if (bus.rx_valid === 1'b1) vc++;
      n_checks++; if (vc !== 0) $display("FAIL abort_valid[%0d]: got %0d exp 0", t, vc); else n_pass++;
      n_checks++; if (dut.state !== IDLE) $display("FAIL abort_state[%0d]: got %0d exp %0d", t, dut.state, IDLE); else n_pass++;
      n_checks++; if (bus.rx_data !== m_rx_data) $display("FAIL abort_rx_data[%0d]: got %h exp %h", t, bus.rx_data, m_rx_data); else n_pass++;
      n_checks++; if (dut.rd_addr_seen !== m_rd_seen) $display("FAIL abort_seen[%0d]: got %b exp %b", t, dut.rd_addr_seen, m_rd_seen); else n_pass++;
`ifdef SPI_FRAME_ERR_EN
      n_checks++; if (bus.frame_err !== (k > 0)) $display("FAIL abort_err[%0d]: got %b exp %b", t, bus.frame_err, (k > 0)); else n_pass++;
      tick();
      n_checks++; if (bus.frame_err !== 1'b0) $display("FAIL abort_err_pulse[%0d]: got %b exp 0", t, bus.frame_err); else n_pass++;
`endif
    end
    // Abort in the middle of a MISO shift
    if (!m_rd_seen) begin
      w = {2'b10, 8'($urandom)};
      send_frame(w, 0, vc, vl, got);
      end_frame();
      model_complete(w);
    end
    w = {2'b11, 8'($urandom)};
    d = 8'($urandom);
    send_frame(w, 0, vc, vl, got);
    model_complete(w);
    bus.tx_valid = 1'b1; bus.tx_data = d;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.MISO !== d[ADDR_SIZE-1-i]) $display("FAIL abort_shift_bit[%0d]: got %b exp %b", i, bus.MISO, d[ADDR_SIZE-1-i]); else n_pass++;
    end
    end_frame();
    bus.tx_valid = 1'b0;
    n_checks++; if (bus.MISO !== 1'b0) $display("FAIL abort_shift_miso: got %b exp 0", bus.MISO); else n_pass++;
    n_checks++; if (dut.state !== IDLE) $display("FAIL abort_shift_state: got %0d exp %0d", dut.state, IDLE); else n_pass++;
`ifdef SPI_FRAME_ERR_EN
    n_checks++; if (bus.frame_err !== 1'b1) $display("FAIL abort_shift_err: got %b exp 1", bus.frame_err); else n_pass++;
`endif
    tick();
    n_checks++; if (bus.MISO !== 1'b0) $display("FAIL abort_shift_miso_after: got %b exp 0", bus.MISO); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [RX_W-1:0] w, got;
    logic [ADDR_SIZE-1:0] d;
    int vc, vl;
    // Reset during a MISO shift
    if (!m_rd_seen) begin
      w = {2'b10, 8'($urandom)};
      send_frame(w, 0, vc, vl, got);
      end_frame();
      model_complete(w);
    end
    w = {2'b11, 8'($urandom)};
    d = 8'($urandom) | 8'h10;
    send_frame(w, 0, vc, vl, got);
    bus.tx_valid = 1'b1; bus.tx_data = d;
    tick();
    for (int i = 0; i < 4; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    bus.SS_n = 1'b1; bus.tx_valid = 1'b0;
    m_rx_data = '0; m_rd_seen = 1'b0;
    n_checks++; if (bus.MISO !== 1'b0) $display("FAIL rstmid_miso: got %b exp 0", bus.MISO); else n_pass++;
    n_checks++; if (bus.rx_valid !== 1'b0) $display("FAIL rstmid_rx_valid: got %b exp 0", bus.rx_valid); else n_pass++;
    n_checks++; if (dut.state !== IDLE) $display("FAIL rstmid_state: got %0d exp %0d", dut.state, IDLE); else n_pass++;
    n_checks++; if (bus.rx_data !== m_rx_data) $display("FAIL rstmid_rx_data: got %h exp %h", bus.rx_data, m_rx_data); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    // Reset part-way through a frame while an address read is pending
    w = {2'b10, 8'($urandom)};
    send_frame(w, 0, vc, vl, got);
    end_frame();
    model_complete(w);
    n_checks++; if (dut.rd_addr_seen !== m_rd_seen) $display("FAIL rstmid_seen_pre: got %b exp %b", dut.rd_addr_seen, m_rd_seen); else n_pass++;
    bus.SS_n = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin bus.MOSI = 1'($urandom); tick(); end
    #2 rst_n = 1'b0;
    #1;
    bus.SS_n = 1'b1;
    m_rx_data = '0; m_rd_seen = 1'b0;
    n_checks++; if (dut.rd_addr_seen !== m_rd_seen) $display("FAIL rstmid_seen: got %b exp %b", dut.rd_addr_seen, m_rd_seen); else n_pass++;
    n_checks++; if (dut.state !== IDLE) $display("FAIL rstmid_state2: got %0d exp %0d", dut.state, IDLE); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    // Normal operation resumes after reset
    w = {2'b00, 8'($urandom)};
    send_frame(w, 1, vc, vl, got);
    n_checks++; if (vc !== 1 || vl !== 1 || got !== w) $display("FAIL rstmid_recover: got %0d/%0d/%h exp 1/1/%h", vc, vl, got, w); else n_pass++;
    end_frame();
    model_complete(w);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_routing();
    test_random_mix();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
